// File: rtl/onehot_ring_sequencer.sv
// One-hot ring sequencer: N states stepped forward/backward on x_in (level or edge),
// with synchronous load, wrap pulse and recovery from illegal encodings.
module onehot_ring_sequencer #(
    parameter int unsigned N_STATES  = 3,
    parameter bit          EDGE_MODE = 1'b0,
    parameter int unsigned RESET_IDX = 0,
    localparam int unsigned IDXW     = (N_STATES > 1) ? $clog2(N_STATES) : 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                x_in,
    input  logic                dir,
    input  logic                load,
    input  logic [IDXW-1:0]     load_idx,
    output logic [N_STATES-1:0] state,
    output logic [IDXW-1:0]     state_idx,
    output logic                wrap,
    output logic                err
);

    localparam logic [IDXW-1:0]     LAST_IDX = IDXW'(N_STATES - 1);
    localparam logic [IDXW-1:0]     RST_IDX  = IDXW'(RESET_IDX);
    localparam logic [N_STATES-1:0] ONE      = N_STATES'(1);

    logic            x_prev;
    logic            step;
    logic            legal;
    logic [IDXW-1:0] next_idx;
    logic            next_wrap;
    logic            next_err;

    assign step  = EDGE_MODE ? (x_in & ~x_prev) : x_in;
    // Exactly one bit set: non-zero and clearing the lowest set bit leaves nothing.
    assign legal = (state != '0) && ((state & (state - ONE)) == '0);

    always_comb begin
        next_idx  = state_idx;
        next_wrap = 1'b0;
        next_err  = 1'b0;
        if (!legal) begin
            next_idx = RST_IDX;
            next_err = 1'b1;
        end else if (load) begin
            if (32'(load_idx) < N_STATES) begin
                next_idx = load_idx;
            end else begin
                next_idx = RST_IDX;
                next_err = 1'b1;
            end
        end else if (step) begin
            if (!dir) begin
                if (state_idx == LAST_IDX) begin
                    next_idx  = '0;
                    next_wrap = 1'b1;
                end else begin
                    next_idx = state_idx + 1'b1;
                end
            end else begin
                if (state_idx == '0) begin
                    next_idx  = LAST_IDX;
                    next_wrap = 1'b1;
                end else begin
                    next_idx = state_idx - 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ONE << RST_IDX;
            state_idx <= RST_IDX;
            wrap      <= 1'b0;
            err       <= 1'b0;
            x_prev    <= 1'b0;
        end else begin
            state     <= ONE << next_idx;
            state_idx <= next_idx;
            wrap      <= next_wrap;
            err       <= next_err;
            x_prev    <= x_in;
        end
    end

endmodule

// File: tb/tb_onehot_ring_sequencer.sv
// Bench for onehot_ring_sequencer: several parameterisations share stimulus; a reference
// model pushes expected results into a queue that is popped and compared after each edge.
module tb_onehot_ring_sequencer;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       x_in = 1'b0;
    logic       dir = 1'b0;
    logic       load = 1'b0;
    logic [2:0] li = 3'd0;

    always #5 clk = ~clk;

    logic [2:0] s0, s2;
    logic [4:0] s1;
    logic [3:0] s3, s4;
    logic [1:0] i0, i2, i3, i4;
    logic [2:0] i1;
    logic [4:0] w, e;

    onehot_ring_sequencer #(.N_STATES(3), .EDGE_MODE(1'b0), .RESET_IDX(0)) u0 (
        .clk(clk), .reset(reset), .x_in(x_in), .dir(dir), .load(load), .load_idx(li[1:0]),
        .state(s0), .state_idx(i0), .wrap(w[0]), .err(e[0]));
    onehot_ring_sequencer #(.N_STATES(5), .EDGE_MODE(1'b0), .RESET_IDX(0)) u1 (
        .clk(clk), .reset(reset), .x_in(x_in), .dir(dir), .load(load), .load_idx(li),
        .state(s1), .state_idx(i1), .wrap(w[1]), .err(e[1]));
    onehot_ring_sequencer #(.N_STATES(3), .EDGE_MODE(1'b1), .RESET_IDX(0)) u2 (
        .clk(clk), .reset(reset), .x_in(x_in), .dir(dir), .load(load), .load_idx(li[1:0]),
        .state(s2), .state_idx(i2), .wrap(w[2]), .err(e[2]));
    onehot_ring_sequencer #(.N_STATES(4), .EDGE_MODE(1'b0), .RESET_IDX(0)) u3 (
        .clk(clk), .reset(reset), .x_in(x_in), .dir(dir), .load(load), .load_idx(li[1:0]),
        .state(s3), .state_idx(i3), .wrap(w[3]), .err(e[3]));
    onehot_ring_sequencer #(.N_STATES(4), .EDGE_MODE(1'b0), .RESET_IDX(1)) u4 (
        .clk(clk), .reset(reset), .x_in(x_in), .dir(dir), .load(load), .load_idx(li[1:0]),
        .state(s4), .state_idx(i4), .wrap(w[4]), .err(e[4]));

    int unsigned n_tab [5] = '{3, 5, 3, 4, 4};
    bit          e_tab [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    int unsigned r_tab [5] = '{0, 0, 0, 0, 1};

    int sel = 0;
    logic [7:0] obs_state;
    logic [2:0] obs_idx;
    logic       obs_wrap, obs_err;

    always_comb begin
        obs_state = '0;
        obs_idx   = '0;
        case (sel)
            0: begin obs_state = 8'(s0); obs_idx = 3'(i0); end
            1: begin obs_state = 8'(s1); obs_idx = i1;     end
            2: begin obs_state = 8'(s2); obs_idx = 3'(i2); end
            3: begin obs_state = 8'(s3); obs_idx = 3'(i3); end
            default: begin obs_state = 8'(s4); obs_idx = 3'(i4); end
        endcase
        obs_wrap = w[sel];
        obs_err  = e[sel];
    end

    typedef struct {
        int unsigned idx;
        bit          wrap;
        bit          err;
    } exp_t;

    exp_t exp_q [$];
    int   n_checks = 0;
    int   n_errors = 0;
    int unsigned m_idx = 0;
    bit   m_prev = 1'b0;

    task automatic check(input string tag, input int act, input int expv);
        n_checks++;
        if (act != expv) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, expv);
        end
    endtask

    task automatic compare_all(input string tag, input exp_t x);
        check({tag, " state"}, int'(obs_state), int'(8'(1) << x.idx));
        check({tag, " idx"}, int'(obs_idx), int'(x.idx));
        check({tag, " wrap"}, int'(obs_wrap), int'(x.wrap));
        check({tag, " err"}, int'(obs_err), int'(x.err));
    endtask

    // Model the coming edge from current inputs, queue it, then compare after the edge.
    task automatic expect_edge(input string tag);
        exp_t x;
        int unsigned n = n_tab[sel];
        bit stp = e_tab[sel] ? (x_in & ~m_prev) : x_in;
        m_prev = x_in;
        x.wrap = 1'b0;
        x.err  = 1'b0;
        if (load) begin
            if (int'(li) < int'(n)) m_idx = int'(li);
            else begin
                m_idx = r_tab[sel];
                x.err = 1'b1;
            end
        end else if (stp) begin
            if (!dir) begin
                x.wrap = (m_idx == n - 1);
                m_idx  = x.wrap ? 0 : m_idx + 1;
            end else begin
                x.wrap = (m_idx == 0);
                m_idx  = x.wrap ? n - 1 : m_idx - 1;
            end
        end
        x.idx = m_idx;
        exp_q.push_back(x);
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) check({tag, " queue"}, 0, 1);
        else compare_all(tag, exp_q.pop_front());
    endtask

    task automatic cycle(input string tag, input bit x, input bit d, input bit l,
                         input logic [2:0] idx);
        @(negedge clk);
        x_in = x;
        dir  = d;
        load = l;
        li   = idx;
        expect_edge(tag);
    endtask

    task automatic do_reset(input string tag, input bit x);
        exp_t r;
        @(negedge clk);
        reset = 1'b0;
        x_in  = x;
        dir   = 1'b0;
        load  = 1'b0;
        li    = 3'd0;
        #1;
        r.idx  = r_tab[sel];
        r.wrap = 1'b0;
        r.err  = 1'b0;
        compare_all({tag, " in_reset"}, r);
        @(negedge clk);
        reset  = 1'b1;
        m_idx  = r_tab[sel];
        m_prev = 1'b0;
        expect_edge({tag, " release"});
    endtask

    initial begin
        exp_t x;

        // Legacy 3-state ring
        sel = 0;
        do_reset("t1", 1'b0);
        for (int k = 0; k < 4; k++) cycle("t1 step", 1'b1, 1'b0, 1'b0, 3'd0);
        cycle("t1 hold", 1'b0, 1'b1, 1'b0, 3'd0);

        // Backward wrap on N=5
        sel = 1;
        do_reset("t2", 1'b0);
        cycle("t2 back_wrap", 1'b1, 1'b1, 1'b0, 3'd0);
        cycle("t2 back", 1'b1, 1'b1, 1'b0, 3'd0);
        cycle("t2 dir_only", 1'b0, 1'b0, 1'b0, 3'd0);
        cycle("t2 load_oor", 1'b1, 1'b0, 1'b1, 3'd7);
        cycle("t2 err_clear", 1'b0, 1'b0, 1'b0, 3'd0);
        cycle("t2 load4", 1'b0, 1'b0, 1'b1, 3'd4);
        cycle("t2 fwd_wrap", 1'b1, 1'b0, 1'b0, 3'd0);

        // Edge mode: x_in high across release steps once, then needs a fresh edge
        sel = 2;
        do_reset("t3", 1'b1);
        for (int k = 0; k < 4; k++) cycle("t3 held", 1'b1, 1'b0, 1'b0, 3'd0);
        cycle("t3 low", 1'b0, 1'b0, 1'b0, 3'd0);
        cycle("t3 rise", 1'b1, 1'b0, 1'b0, 3'd0);
        cycle("t3 held2", 1'b1, 1'b0, 1'b0, 3'd0);

        // Load beats a simultaneous step
        sel = 3;
        do_reset("t4", 1'b0);
        cycle("t4 load_vs_step", 1'b1, 1'b0, 1'b1, 3'd2);
        cycle("t4 load3", 1'b0, 1'b0, 1'b1, 3'd3);
        cycle("t4 wrap", 1'b1, 1'b0, 1'b0, 3'd0);
        cycle("t4 after_wrap", 1'b0, 1'b0, 1'b0, 3'd0);

        // Illegal encoding recovery, and it outranks load
        sel = 4;
        do_reset("t5", 1'b0);
        @(negedge clk);
        force u4.state = 4'b0110;
        #1;
        release u4.state;
        x_in = 1'b1;
        load = 1'b1;
        li   = 3'd3;
        m_prev = 1'b1;
        m_idx  = 1;
        x.idx = 1; x.wrap = 1'b0; x.err = 1'b1;
        exp_q.push_back(x);
        @(posedge clk);
        #1;
        compare_all("t5 recover", exp_q.pop_front());
        cycle("t5 err_clear", 1'b0, 1'b0, 1'b0, 3'd0);
        cycle("t5 step", 1'b1, 1'b0, 1'b0, 3'd0);

        // Asynchronous reset mid-sequence
        sel = 0;
        do_reset("t6", 1'b0);
        cycle("t6 a", 1'b1, 1'b0, 1'b0, 3'd0);
        cycle("t6 b", 1'b1, 1'b0, 1'b0, 3'd0);
        #2;
        reset = 1'b0;
        #1;
        x.idx = 0; x.wrap = 1'b0; x.err = 1'b0;
        compare_all("t6 async", x);
        @(negedge clk);
        reset  = 1'b1;
        x_in   = 1'b1;
        m_idx  = 0;
        m_prev = 1'b0;
        expect_edge("t6 resume");
        cycle("t6 resume2", 1'b1, 1'b0, 1'b0, 3'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
